// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_arb_pkg;

  typedef enum logic {S_INIT, S_RUN} arb_state_t;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned LAST_REG = NUM_REGS - 1;

  // Index width for an N-entry one-hot vector (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Rotate-priority round-robin pick: the search starts one past the last winner.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Scan ptr+1 .. ptr+N (mod N); first requester found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = IDX_W'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found     = 1'b1;
        gnt[pos]  = 1'b1;
        gnt_idx   = pos;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-sweeps x1..x31 after reset, then
// shares the port among N_REQ writeback requesters in round-robin order.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RA_W       = 5,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*RA_W-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [2*RA_W-1:0]       chk_addr,
  output logic [1:0]              chk_hazard,
  output logic                    rf_we3,
  output logic [RA_W-1:0]         rf_a3,
  output logic [XLEN-1:0]         rf_wd3,
  output logic                    init_done
);

  localparam int unsigned     IDX_W       = idx_width(N_REQ);
  localparam arb_state_t      RESET_STATE = INIT_CLEAR ? S_INIT : S_RUN;
  localparam logic [RA_W-1:0] LAST_ADDR   = RA_W'(LAST_REG);

  arb_state_t       state;
  logic [RA_W-1:0]  sweep_ctr;
  logic [IDX_W-1:0] rr_ptr;
  logic             run;
  logic [N_REQ-1:0] req_masked;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             any_gnt;
  logic [RA_W-1:0]  sel_addr;
  logic [XLEN-1:0]  sel_data;

  assign run        = (state == S_RUN);
  assign req_masked = req_valid & {N_REQ{run}};
  assign any_gnt    = |gnt;
  assign req_ready  = gnt;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_masked),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // One-hot mux of the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*RA_W +: RA_W];
        sel_data = sel_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Read-after-write hazard: decoded source matches the write on the port now.
  always_comb begin
    chk_hazard = '0;
    for (int unsigned j = 0; j < 2; j++) begin
      chk_hazard[j] = run && rf_we3 && (rf_a3 != '0) &&
                      (rf_a3 == chk_addr[j*RA_W +: RA_W]);
    end
  end

  // Sweep/run FSM with registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_STATE;
      sweep_ctr <= RA_W'(1);
      rr_ptr    <= IDX_W'(N_REQ - 1);
      rf_we3    <= 1'b0;
      rf_a3     <= '0;
      rf_wd3    <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          // The cycle after x31 is presented ends the sweep.
          if (rf_we3 && (rf_a3 == LAST_ADDR)) begin
            state     <= S_RUN;
            rf_we3    <= 1'b0;
            init_done <= 1'b1;
          end else begin
            rf_we3    <= 1'b1;
            rf_a3     <= sweep_ctr;
            rf_wd3    <= '0;
            sweep_ctr <= sweep_ctr + RA_W'(1);
          end
        end
        S_RUN: begin
          init_done <= 1'b1;
          if (any_gnt) begin
            rr_ptr <= gnt_idx;
            // x0 requests are consumed but never reach the register file.
            if (sel_addr != '0) begin
              rf_we3 <= 1'b1;
              rf_a3  <= sel_addr;
              rf_wd3 <= sel_data;
            end else begin
              rf_we3 <= 1'b0;
            end
          end else begin
            rf_we3 <= 1'b0;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (three requesters).
module tb_regfile_write_arbiter;

  localparam int N    = 3;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct {
    logic [RA_W-1:0] a;
    logic [XLEN-1:0] d;
    int              cyc;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N*RA_W-1:0]     req_addr;
  logic [N*XLEN-1:0]     req_data;
  logic [N-1:0]          req_ready;
  logic [2*RA_W-1:0]     chk_addr;
  logic [1:0]            chk_hazard;
  logic                  rf_we3;
  logic [RA_W-1:0]       rf_a3;
  logic [XLEN-1:0]       rf_wd3;
  logic                  init_done;

  bit              v [N];
  logic [RA_W-1:0] a [N];
  logic [XLEN-1:0] d [N];
  logic [RA_W-1:0] chk0, chk1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model state
  wr_t             sb[$];
  int              mdl_ptr;
  bit              mdl_run;
  int              init_left;
  bit              mdl_we;
  logic [RA_W-1:0] mdl_a;
  int              last_g;
  logic [RA_W-1:0] last_a;
  logic [XLEN-1:0] last_d;
  wr_t             mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]              = v[i];
      req_addr[i*RA_W +: RA_W]  = a[i];
      req_data[i*XLEN +: XLEN]  = d[i];
    end
  end
  assign chk_addr = {chk1, chk0};

  regfile_write_arbiter #(
    .N_REQ      (N),
    .XLEN       (XLEN),
    .RA_W       (RA_W),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .chk_addr   (chk_addr),
    .chk_hazard (chk_hazard),
    .rf_we3     (rf_we3),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3),
    .init_done  (init_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle the write port either shows the next expected write
  // or holds its last written address/data with the enable low.
  always @(negedge clk) begin
    if (reset) begin
      last_a = '0;
      last_d = '0;
    end else if (rf_we3) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        chk("unexpected_write_we3", 64'(rf_we3), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("write_addr", 64'(rf_a3), 64'(mon_e.a));
        chk("write_data", 64'(rf_wd3), 64'(mon_e.d));
        last_a = mon_e.a;
        last_d = mon_e.d;
      end
    end else begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        chk("missing_write_we3", 64'(rf_we3), 64'(1));
        mon_e = sb.pop_front();
      end
      chk("hold_addr", 64'(rf_a3), 64'(last_a));
      chk("hold_data", 64'(rf_wd3), 64'(last_d));
    end
  end

  // Spec-level model of one cycle: round-robin pick, hazard, init status.
  task automatic evaluate();
    logic [N-1:0] er;
    logic [1:0]   eh;
    int           g;
    er = '0;
    g  = -1;
    if (mdl_run) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (mdl_ptr + k) % N;
        if (g < 0 && v[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    eh[0] = mdl_we && (chk0 == mdl_a);
    eh[1] = mdl_we && (chk1 == mdl_a);
    chk("chk_hazard", 64'(chk_hazard), 64'(eh));
    chk("init_done", 64'(init_done), 64'(mdl_run));
    mdl_we = 1'b0;
    if (g >= 0) begin
      mdl_ptr = g;
      if (a[g] != '0) begin
        sb.push_back('{a: a[g], d: d[g], cyc: cyc + 1});
        mdl_we = 1'b1;
        mdl_a  = a[g];
      end
    end
    if (!mdl_run) begin
      init_left--;
      if (init_left == 0) mdl_run = 1'b1;
    end
    last_g = g;
  endtask

  task automatic one_cycle();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
  endtask

  // Async reset: outputs must clear at once; release off-edge and expect the sweep.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_we3", 64'(rf_we3), 64'(0));
    chk("rst_a3", 64'(rf_a3), 64'(0));
    chk("rst_wd3", 64'(rf_wd3), 64'(0));
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_hazard", 64'(chk_hazard), 64'(0));
    sb.delete();
    mdl_ptr   = N - 1;
    mdl_run   = 1'b0;
    mdl_we    = 1'b0;
    mdl_a     = '0;
    last_g    = -1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    init_left = 31;
    for (int r = 1; r <= 31; r++) sb.push_back('{a: RA_W'(r), d: '0, cyc: cyc + r});
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    chk0 = RA_W'($urandom);
    chk1 = RA_W'($urandom);
  endtask

  // Requesters hold until accepted, occasionally withdraw, and pick new writes.
  task automatic drive_random(input int pct);
    if (last_g >= 0) v[last_g] = 1'b0;
    last_g = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i] && $urandom_range(0, 19) == 0) begin
        v[i] = 1'b0;
      end else if (!v[i] && $urandom_range(0, 99) < pct) begin
        v[i] = 1'b1;
        a[i] = ($urandom_range(0, 7) == 0) ? '0 : RA_W'($urandom_range(1, 31));
        d[i] = $urandom;
      end
    end
    chk0 = ($urandom_range(0, 1) == 1) ? mdl_a : RA_W'($urandom);
    chk1 = ($urandom_range(0, 1) == 1) ? mdl_a : RA_W'($urandom);
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      if (rnd) drive_random(70);
      else idle();
      one_cycle();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      a[i] = '0;
      d[i] = '0;
    end
    chk0 = '0;
    chk1 = '0;
    mdl_a = '0;
    last_a = '0;
    last_d = '0;

    // Sweep with requesters active: no grants until init_done
    apply_reset();
    run_cycles(35, 1'b1);

    // Single write from r0 and its hazard window
    idle();
    one_cycle();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
    chk0 = 5'd5; chk1 = 5'd3;
    @(negedge clk);
    chk("dir_ready_r0", 64'(req_ready), 64'(3'b001));
    evaluate();
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(negedge clk);
    chk("dir_hazard_rs1", 64'(chk_hazard), 64'(2'b01));
    evaluate();
    @(posedge clk); #1;

    // Two continuous requesters alternate, r0 first after reset
    apply_reset();
    run_cycles(32, 1'b0);
    for (int k = 0; k < 6; k++) begin
      v[0] = 1'b1; a[0] = 5'd1; d[0] = 32'h11;
      v[1] = 1'b1; a[1] = 5'd2; d[1] = 32'h22;
      v[2] = 1'b0;
      @(negedge clk);
      chk("alt_grant", 64'(req_ready), (k % 2 == 0) ? 64'(3'b001) : 64'(3'b010));
      evaluate();
      @(posedge clk); #1;
    end

    // x0 write: accepted, never written
    idle();
    v[1] = 1'b1; a[1] = 5'd0; d[1] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("x0_ready", 64'(req_ready), 64'(3'b010));
    evaluate();
    @(posedge clk); #1;
    run_cycles(2, 1'b0);

    // Reset mid-sweep at x12, then sweep restarts at x1
    apply_reset();
    idle();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      evaluate();
      if (rf_a3 == 5'd12) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("sweep_reached_x12", 64'(found), 64'(1));
    #2;
    apply_reset();
    run_cycles(32, 1'b0);

    // Reset while a RUN write is on the port
    v[0] = 1'b1; a[0] = 5'd7; d[0] = 32'hCAFE0007;
    one_cycle();
    chk("pending_we3_before_reset", 64'(rf_we3), 64'(1));
    #1;
    apply_reset();
    idle();
    run_cycles(32, 1'b0);

    // Three requesters: r0, then only r2, then idle hold
    idle();
    v[0] = 1'b1; a[0] = 5'd9; d[0] = $urandom;
    @(negedge clk);
    chk("n3_r0_grant", 64'(req_ready), 64'(3'b001));
    evaluate();
    @(posedge clk); #1;
    v[0] = 1'b0;
    v[2] = 1'b1; a[2] = 5'd31; d[2] = 32'hA5A5_0031;
    @(negedge clk);
    chk("n3_r2_grant", 64'(req_ready), 64'(3'b100));
    evaluate();
    @(posedge clk); #1;
    run_cycles(3, 1'b0);

    // Randomized traffic
    run_cycles(2000, 1'b1);

    // Drain
    run_cycles(4, 1'b0);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
